spi_subnode_frame_ctrl: RTL

Serial-to-parallel front end for the AES encrypt/decrypt core. It receives framed commands from the Master World over a chip-select/serial-data link clocked by in_clk. Each frame is a command byte, a message block and an optional key. The block launches the core with a start/done handshake, then streams the result back MSB first. It generalises the previous subnode with configurable key and block sizes, encrypt/decrypt mode select, key reuse across frames, abort on chip-select release, and error reporting.

---
 rtl/spi_subnode_frame_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_subnode_frame_ctrl.sv
// Serial command/message/key front end for the AES core: deserialises a framed
// request, runs the start/done handshake, then streams the result MSB first.
module spi_subnode_frame_ctrl #(
  parameter int nk    = 8,
  parameter int nb    = 4,
  parameter int CMD_W = 8,
  localparam int KEY_W = 32 * nk,
  localparam int MSG_W = 32 * nb
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sdi,
  output logic             sdo,
  input  logic [MSG_W-1:0] from_enc_dec_msg,
  input  logic             core_done,
  output logic [MSG_W-1:0] to_enc_dec_msg,
  output logic [KEY_W-1:0] to_enc_dec_key,
  output logic             enc_mode,
  output logic             core_start,
  output logic             busy,
  output logic             key_valid,
  output logic             error
);

  localparam int MAX_W = (KEY_W > MSG_W) ? ((KEY_W > CMD_W) ? KEY_W : CMD_W)
                                         : ((MSG_W > CMD_W) ? MSG_W : CMD_W);
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_MSG, S_KEY, S_START, S_WAIT, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CMD_W-2:0]   cmd_q, cmd_d;
  logic               key_reuse_q, key_reuse_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [MSG_W-1:0]   piso_q, piso_d;
  logic               mode_q, mode_d;
  logic               key_valid_q, key_valid_d;
  logic               error_q, error_d;

  logic [CMD_W-1:0]   cmd_full;
  logic               cmd_bad;
  logic               last_cmd, last_msg, last_key;

  assign cmd_full = {cmd_q, sdi};
  // Reserved field must be zero, and key reuse needs a previously completed key.
  assign cmd_bad  = (|cmd_full[CMD_W-3:0]) || (cmd_full[CMD_W-2] && !key_valid_q);
  assign last_cmd = (cnt_q == CNT_W'(CMD_W - 1));
  assign last_msg = (cnt_q == CNT_W'(MSG_W - 1));
  assign last_key = (cnt_q == CNT_W'(KEY_W - 1));

  // State register
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cs) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_CMD;
        S_CMD:   if (last_cmd) state_d = cmd_bad ? S_ERR : S_MSG;
        S_MSG:   if (last_msg) state_d = key_reuse_q ? S_START : S_KEY;
        S_KEY:   if (last_key) state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT:  if (core_done) state_d = S_OUT;
        S_OUT:   if (last_msg) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      cmd_q       <= '0;
      key_reuse_q <= 1'b0;
      msg_q       <= '0;
      key_q       <= '0;
      piso_q      <= '0;
      mode_q      <= 1'b0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      key_reuse_q <= key_reuse_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      piso_q      <= piso_d;
      mode_q      <= mode_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    key_reuse_d = key_reuse_q;
    msg_d       = msg_q;
    key_d       = key_q;
    piso_d      = piso_q;
    mode_d      = mode_q;
    key_valid_d = key_valid_q;
    error_d     = error_q;
    if (cs) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_d   = {{(CMD_W-2){1'b0}}, sdi};
          cnt_d   = CNT_W'(1);
          error_d = 1'b0;
        end
        S_CMD: begin
          cmd_d = cmd_full[CMD_W-2:0];
          if (last_cmd) begin
            cnt_d = '0;
            if (cmd_bad) begin
              error_d = 1'b1;
            end else begin
              mode_d      = cmd_full[CMD_W-1];
              key_reuse_d = cmd_full[CMD_W-2];
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_MSG: begin
          msg_d = {msg_q[MSG_W-2:0], sdi};
          cnt_d = last_msg ? '0 : cnt_q + CNT_W'(1);
        end
        S_KEY: begin
          key_d = {key_q[KEY_W-2:0], sdi};
          // A partially shifted key must never look usable, so drop valid up front.
          if (cnt_q == '0) key_valid_d = 1'b0;
          if (last_key) begin
            key_valid_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (core_done) begin
            piso_d = from_enc_dec_msg;
            cnt_d  = '0;
          end
        end
        S_OUT: begin
          piso_d = {piso_q[MSG_W-2:0], 1'b0};
          cnt_d  = last_msg ? '0 : cnt_q + CNT_W'(1);
        end
        S_ERR:   error_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    core_start = (state_q == S_START);
    busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  end

  assign sdo            = (state_q == S_OUT) ? piso_q[MSG_W-1] : 1'bz;
  assign to_enc_dec_msg = msg_q;
  assign to_enc_dec_key = key_q;
  assign enc_mode       = mode_q;
  assign key_valid      = key_valid_q;
  assign error          = error_q;

endmodule
